// File: rtl/pim_buf_dma_pkg.sv
// -----------------------------------------------------------------------------
// pim_buf_pkg
// Shared types and constants for the PIM buffer DMA initiator.
//   pim_dma_state_e  : FSM state encoding, also exported as a debug output
//   DIR_RD / DIR_WR  : command direction encodings
//   word_idx_width() : width of the word index derived from the byte-address width
// -----------------------------------------------------------------------------
package pim_buf_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_DRAIN = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } pim_dma_state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // Byte address bits minus the two byte-lane bits.
    function automatic int word_idx_width(input int mem_addr_width);
        return mem_addr_width - 2;
    endfunction

endpackage

// File: rtl/pim_buf_dma_if.sv
// -----------------------------------------------------------------------------
// pim_buf_dma_if
// PIM buffer SRAM port. Signal names are seen from the DMA (initiator) side.
//   o_buf_addr     byte address, word aligned
//   i_buf_rd_data  read data, valid the cycle after the address
//   o_buf_wr_data  write data
//   o_buf_size     byte enables
//   o_buf_write    write strobe
//   o_buf_read     read / write-disable, always the inverse of o_buf_write
// Modports: master = DMA, slave = buffer.
// -----------------------------------------------------------------------------
interface pim_buf_dma_if;

    logic [31:0] o_buf_addr;
    logic [31:0] i_buf_rd_data;
    logic [31:0] o_buf_wr_data;
    logic [3:0]  o_buf_size;
    logic        o_buf_write;
    logic        o_buf_read;

    modport master (
        output o_buf_addr,
        output o_buf_wr_data,
        output o_buf_size,
        output o_buf_write,
        output o_buf_read,
        input  i_buf_rd_data
    );

    modport slave (
        input  o_buf_addr,
        input  o_buf_wr_data,
        input  o_buf_size,
        input  o_buf_write,
        input  o_buf_read,
        output i_buf_rd_data
    );

endinterface

// File: rtl/pim_buf_dma_rd_fifo.sv
// -----------------------------------------------------------------------------
// pim_buf_rd_fifo
// Synchronous FIFO holding buffer read returns until the stream sink takes them.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push         write i_push_data (ignored when full with no pop)
//   i_pop          remove head (ignored when empty)
//   o_head         current head entry
//   o_empty        no entries
//   o_count        number of entries, 0..DEPTH
// Push and pop in the same cycle are both honoured.
// -----------------------------------------------------------------------------
module pim_buf_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pim_buf_dma.sv
// -----------------------------------------------------------------------------
// pim_buf_dma
// Initiator side of the PIM buffer SRAM port. A command (dir, base, len) either
// streams len words out of the buffer onto a valid/ready read stream, or takes
// len beats from a valid/ready write stream into the buffer.
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready   command handshake, accepted only in IDLE
//   o_busy / o_done       command in progress / one-cycle completion pulse
//   o_rd_valid/i_rd_ready/o_rd_data            read stream
//   i_wr_valid/o_wr_ready/i_wr_data/i_wr_strb  write stream
//   io_buf                buffer SRAM port (master side)
//   o_state               current FSM state (debug)
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid does not wait for ready, and command fields are only
// sampled on the accepting edge.
// -----------------------------------------------------------------------------
module pim_buf_dma
    import pim_buf_pkg::*;
#(
    parameter int MEM_DEPTH      = 28672,
    parameter int MEM_ADDR_WIDTH = 15,
    parameter int FIFO_DEPTH     = 4,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_dir,
    input  logic [31:0]          i_cmd_base,
    input  logic [LEN_WIDTH-1:0] i_cmd_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [31:0]          o_rd_data,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [31:0]          i_wr_data,
    input  logic [3:0]           i_wr_strb,
    pim_buf_dma_if.master        io_buf,
    output pim_dma_state_e       o_state
);

    localparam int IW = word_idx_width(MEM_ADDR_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MEM_DEPTH / 4 - 1);

    pim_dma_state_e       r_state;
    logic [IW-1:0]        r_idx;        // next word index to access
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_count;      // accesses issued so far
    logic                 r_addr_vld;   // read address on the bus this cycle
    logic                 r_ret_vld;    // read data on i_buf_rd_data this cycle
    logic [31:0]          r_buf_addr;
    logic [31:0]          r_buf_wr_data;
    logic [3:0]           r_buf_size;
    logic                 r_buf_write;

    logic [CW-1:0]        w_fifo_cnt;
    logic                 w_fifo_empty;
    logic [31:0]          w_fifo_head;
    logic                 w_pop;
    logic [CW:0]          w_occ;
    logic                 w_issue;
    logic                 w_last;
    logic                 w_cmd_hs;
    logic [IW-1:0]        w_idx_next;
    logic [31:0]          w_cur_addr;
    logic                 w_unused_base;

    assign w_unused_base = ^{i_cmd_base[31:MEM_ADDR_WIDTH], i_cmd_base[1:0]};

    assign w_cmd_hs   = i_cmd_valid && o_cmd_ready;
    assign w_pop      = !w_fifo_empty && i_rd_ready;
    // Reserve FIFO space for every read already in flight, so a return can
    // always be pushed no matter how long the sink stalls.
    assign w_occ      = {1'b0, w_fifo_cnt} + (CW+1)'(r_addr_vld) + (CW+1)'(r_ret_vld);
    assign w_issue    = (r_state == RD) && (r_count != r_len) && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_last     = (r_count == r_len - LEN_WIDTH'(1));
    assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    assign w_cur_addr = {{(32-MEM_ADDR_WIDTH){1'b0}}, r_idx, 2'b00};

    pim_buf_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_rd_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_ret_vld),
        .i_push_data (io_buf.i_buf_rd_data),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_addr_vld    <= 1'b0;
            r_ret_vld     <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_wr_data <= '0;
            r_buf_size    <= '0;
            r_buf_write   <= 1'b0;
        end else begin
            r_addr_vld  <= w_issue;
            r_ret_vld   <= r_addr_vld;
            r_buf_write <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_len   <= i_cmd_len;
                        r_count <= '0;
                        r_idx   <= i_cmd_base[MEM_ADDR_WIDTH-1:2];
                        if (i_cmd_len == '0) begin
                            r_state <= DONE;
                        end else if (i_cmd_dir == DIR_WR) begin
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (w_issue) begin
                        r_buf_addr <= w_cur_addr;
                        r_idx      <= w_idx_next;
                        r_count    <= r_count + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (w_fifo_empty && !r_addr_vld && !r_ret_vld) begin
                        r_state <= DONE;
                    end
                end
                WR: begin
                    if (i_wr_valid) begin
                        r_buf_addr    <= w_cur_addr;
                        r_buf_wr_data <= i_wr_data;
                        r_buf_size    <= i_wr_strb;
                        r_buf_write   <= 1'b1;
                        r_idx         <= w_idx_next;
                        r_count       <= r_count + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = (r_state == IDLE) && !i_rst;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_wr_ready  = (r_state == WR);
    assign o_rd_valid  = !w_fifo_empty;
    assign o_rd_data   = w_fifo_head;
    assign o_state     = r_state;

    assign io_buf.o_buf_addr    = r_buf_addr;
    assign io_buf.o_buf_wr_data = r_buf_wr_data;
    assign io_buf.o_buf_size    = r_buf_size;
    assign io_buf.o_buf_write   = r_buf_write;
    assign io_buf.o_buf_read    = ~r_buf_write;

endmodule

// File: tb/tb_pim_buf_dma.sv
// Testbench for pim_buf_dma: buffer SRAM model, reference memory image,
// expected queues for the read stream and the buffer write bus.
module tb_pim_buf_dma;
  import pim_buf_pkg::*;

  localparam int NWORDS = 7168;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_rst;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic           i_cmd_dir;
  logic [31:0]    i_cmd_base;
  logic [15:0]    i_cmd_len;
  logic           o_busy;
  logic           o_done;
  logic           o_rd_valid;
  logic           i_rd_ready;
  logic [31:0]    o_rd_data;
  logic           i_wr_valid;
  logic           o_wr_ready;
  logic [31:0]    i_wr_data;
  logic [3:0]     i_wr_strb;
  pim_dma_state_e o_state;

  pim_buf_dma_if io ();

  pim_buf_dma dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_dir   (i_cmd_dir),
    .i_cmd_base  (i_cmd_base),
    .i_cmd_len   (i_cmd_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .i_wr_valid  (i_wr_valid),
    .o_wr_ready  (o_wr_ready),
    .i_wr_data   (i_wr_data),
    .i_wr_strb   (i_wr_strb),
    .io_buf      (io),
    .o_state     (o_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] sram    [NWORDS];  // the buffer the DUT talks to
  logic [31:0] ref_mem [NWORDS];  // what the buffer must contain

  logic [31:0] rd_exp_q [$];
  logic [31:0] wexp_addr_q [$];
  logic [31:0] wexp_data_q [$];
  logic [3:0]  wexp_strb_q [$];
  logic [31:0] rd_seen [$];
  logic [3:0]  wsz_seen [$];
  logic [31:0] addr_tr [$];
  logic [31:0] wsrc_data [$];
  logic [3:0]  wsrc_strb [$];

  int rd_mode = 0;  // 0 ready high, 1 toggle, 2 random, 3 held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nxt(input int i);
    return (i == NWORDS - 1) ? 0 : i + 1;
  endfunction

  // ---------------- buffer SRAM model (1-cycle read latency) ----------------
  always @(posedge clk) begin
    int          ra;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  ws;
    ra = int'(io.o_buf_addr[14:2]);
    we = io.o_buf_write;
    wd = io.o_buf_wr_data;
    ws = io.o_buf_size;
    #1;
    io.i_buf_rd_data = (ra < NWORDS) ? sram[ra] : 32'h0;
    if (we && ra < NWORDS) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) sram[ra][8*b +: 8] = wd[8*b +: 8];
      end
    end
  end

  // ---------------- read-stream sink ----------------
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: i_rd_ready = 1'b1;
      1: i_rd_ready = ~i_rd_ready;
      2: i_rd_ready = 1'($urandom_range(0, 1));
      default: i_rd_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (!i_rst) begin
      check("buf_read_inv", 32'(io.o_buf_read ^ io.o_buf_write), 32'd1);
      if (o_rd_valid && i_rd_ready) begin
        rd_seen.push_back(o_rd_data);
        if (rd_exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rd_extra: got 0x%08h, expected no beat", o_rd_data);
        end else begin
          check("rd_data", o_rd_data, rd_exp_q.pop_front());
        end
      end
      if (io.o_buf_write) begin
        wsz_seen.push_back(io.o_buf_size);
        if (wexp_addr_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL wr_extra: got addr 0x%08h, expected no write", io.o_buf_addr);
        end else begin
          check("wr_addr", io.o_buf_addr, wexp_addr_q.pop_front());
          check("wr_data", io.o_buf_wr_data, wexp_data_q.pop_front());
          check("wr_size", 32'(io.o_buf_size), 32'(wexp_strb_q.pop_front()));
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_rd_valid", 32'(o_rd_valid), 0);
    check("rst_wr_ready", 32'(o_wr_ready), 0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    check("rst_buf_addr", io.o_buf_addr, 0);
    check("rst_buf_wr_data", io.o_buf_wr_data, 0);
    check("rst_buf_size", 32'(io.o_buf_size), 0);
    check("rst_buf_write", 32'(io.o_buf_write), 0);
    check("rst_buf_read", 32'(io.o_buf_read), 1);
  endtask

  // Runs one command to completion. Entered and left #1 after a rising edge.
  task automatic do_cmd(input logic dir, input logic [31:0] base, input int len);
    int          idx;
    int          cyc;
    int          beats;
    int          budget;
    logic        done_seen;
    logic [31:0] addr0;
    logic [3:0]  s;
    rd_exp_q.delete();
    wexp_addr_q.delete();
    wexp_data_q.delete();
    wexp_strb_q.delete();
    addr_tr.delete();
    idx = int'(base[14:2]);
    if (dir == DIR_RD) begin
      for (int i = 0; i < len; i++) begin
        rd_exp_q.push_back(ref_mem[idx]);
        idx = nxt(idx);
      end
    end
    idx = int'(base[14:2]);
    i_cmd_valid = 1'b1;
    i_cmd_dir   = dir;
    i_cmd_base  = base;
    i_cmd_len   = 16'(len);
    @(negedge clk);
    check("cmd_ready_idle", 32'(o_cmd_ready), 1);
    addr0 = io.o_buf_addr;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_len   = 16'($urandom);
    cyc       = 0;
    beats     = 0;
    done_seen = 1'b0;
    budget    = len * 8 + 40;
    while (!done_seen && cyc < budget) begin
      if (dir == DIR_WR && beats < len) begin
        if (wsrc_data.size() != 0) begin
          i_wr_valid = 1'b1;
          i_wr_data  = wsrc_data[0];
          i_wr_strb  = wsrc_strb[0];
        end else begin
          i_wr_valid = ($urandom_range(0, 3) != 0);
          i_wr_data  = $urandom;
          i_wr_strb  = 4'($urandom_range(0, 15));
        end
      end else begin
        i_wr_valid = 1'b0;
      end
      @(negedge clk);
      addr_tr.push_back(io.o_buf_addr);
      if (cyc == 0) check("busy_after_accept", 32'(o_busy), 1);
      if (o_done) begin
        done_seen = 1'b1;
        check("done_rd_all_delivered", rd_exp_q.size(), 0);
        if (len == 0) check("len0_done_latency", cyc, 0);
      end
      if (i_wr_valid && o_wr_ready) begin
        if (wsrc_data.size() != 0) begin
          void'(wsrc_data.pop_front());
          void'(wsrc_strb.pop_front());
        end
        s = i_wr_strb;
        wexp_addr_q.push_back(32'(idx) << 2);
        wexp_data_q.push_back(i_wr_data);
        wexp_strb_q.push_back(s);
        for (int b = 0; b < 4; b++) begin
          if (s[b]) ref_mem[idx][8*b +: 8] = i_wr_data[8*b +: 8];
        end
        idx = nxt(idx);
        beats++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_wr_valid = 1'b0;
    if (!done_seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL cmd_timeout: got no o_done after %0d cycles, expected one", cyc);
    end
    @(negedge clk);
    check("done_single_pulse", 32'(o_done), 0);
    check("ready_after_done", 32'(o_cmd_ready), 1);
    check("writes_all_seen", wexp_addr_q.size(), 0);
    if (len == 0) begin
      check("len0_addr_unchanged", io.o_buf_addr, addr0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          idx;
    int          len;
    logic        dir;
    logic [31:0] base;
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_dir   = 1'b0;
    i_cmd_base  = '0;
    i_cmd_len   = '0;
    i_rd_ready  = 1'b1;
    i_wr_valid  = 1'b0;
    i_wr_data   = '0;
    i_wr_strb   = '0;
    io.i_buf_rd_data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 32'(o_cmd_ready), 1);
    @(posedge clk);
    #1;

    // Read three words at 0x100, sink always ready.
    rd_mode = 0;
    rd_seen.delete();
    do_cmd(DIR_RD, 32'h100, 3);
    check("t1_addr0", addr_tr[1], 32'h100);
    check("t1_addr1", addr_tr[2], 32'h104);
    check("t1_addr2", addr_tr[3], 32'h108);
    check("t1_beats", rd_seen.size(), 3);

    // Eight words with a toggling sink.
    rd_mode = 1;
    rd_seen.delete();
    do_cmd(DIR_RD, 32'h400, 8);
    check("t2_beats", rd_seen.size(), 8);

    // Two writes, full then partial, then read them back.
    rd_mode = 0;
    wsrc_data.push_back(32'hAABBCCDD);
    wsrc_strb.push_back(4'hF);
    wsrc_data.push_back(32'h11223344);
    wsrc_strb.push_back(4'h3);
    wsz_seen.delete();
    do_cmd(DIR_WR, 32'h20, 2);
    check("t3_size0", 32'(wsz_seen[0]), 32'hF);
    check("t3_size1", 32'(wsz_seen[1]), 32'h3);
    rd_seen.delete();
    do_cmd(DIR_RD, 32'h20, 2);
    check("t3_readback0", rd_seen[0], 32'hAABBCCDD);
    check("t3_readback1_lo", 32'(rd_seen[1][15:0]), 32'h3344);

    // Zero-length commands in both directions.
    do_cmd(DIR_RD, 32'h40, 0);
    do_cmd(DIR_WR, 32'h80, 0);

    // Wrap from the last word back to 0.
    do_cmd(DIR_RD, 32'h6FFC, 2);
    check("t5_addr0", addr_tr[1], 32'h6FFC);
    check("t5_addr1", addr_tr[2], 32'h0);

    // Reset in the middle of a stalled read.
    rd_mode     = 3;
    i_rd_ready  = 1'b0;
    rd_exp_q.delete();
    i_cmd_valid = 1'b1;
    i_cmd_dir   = DIR_RD;
    i_cmd_base  = 32'h200;
    i_cmd_len   = 16'd8;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_fifo_holding", 32'(o_rd_valid), 1);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    i_rst      = 1'b0;
    rd_mode    = 0;
    i_rd_ready = 1'b1;
    rd_seen.delete();
    do_cmd(DIR_RD, 32'h204, 1);
    check("t6_after_reset_word", rd_seen[0], ref_mem[32'h204 >> 2]);

    // Randomized commands, including wraps and ignored address bits.
    for (int k = 0; k < 40; k++) begin
      dir = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 12);
      if ($urandom_range(0, 3) == 0) idx = NWORDS - $urandom_range(1, 6);
      else idx = $urandom_range(0, NWORDS - 1);
      base = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) base = base | (32'($urandom_range(1, 255)) << 20);
      rd_mode = $urandom_range(0, 2);
      do_cmd(dir, base, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
